// File: rtl/up_down_counter.sv
// Synchronous WIDTH-bit up/down counter with single-cycle ovf/unf boundary flags.
// Define UP_DOWN_COUNTER_SATURATE_EN to clamp at the boundaries instead of wrapping.
module up_down_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             counter,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic at_max;
  logic at_min;

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == ZERO_VAL);

  // Flags are registered with the count update, so they line up with the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (counter) begin
      unf <= 1'b0;
      ovf <= at_max;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      if (!at_max) count <= count + ONE_VAL;
`else
      count <= count + ONE_VAL;
`endif
    end else begin
      ovf <= 1'b0;
      unf <= at_min;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      if (!at_min) count <= count - ONE_VAL;
`else
      count <= count - ONE_VAL;
`endif
    end
  end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter (WIDTH=4, RESET_VAL=0); expectations follow
// UP_DOWN_COUNTER_SATURATE_EN when the bench is compiled with it.
module tb_up_down_counter;

  logic       clk;
  logic       rst;
  logic       counter;
  logic [3:0] count;
  logic       ovf;
  logic       unf;

  int total = 0;
  int bad   = 0;

  up_down_counter #(.WIDTH(4), .RESET_VAL(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .counter (counter),
    .count   (count),
    .ovf     (ovf),
    .unf     (unf)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver: advance one edge, settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_c,
                       input logic exp_o, input logic exp_u);
    total++;
    assert (count === exp_c && ovf === exp_o && unf === exp_u)
      else begin
        bad++;
        $error("FAIL %s: got count=%0d ovf=%b unf=%b want count=%0d ovf=%b unf=%b",
               tag, count, ovf, unf, exp_c, exp_o, exp_u);
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    check("reset_pulse", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    logic       eo;
    rst     = 1'b1;
    counter = 1'b1;

    // reset held two edges with counter=1
    step(); check("reset_edge1", 4'd0, 1'b0, 1'b0);
    step(); check("reset_edge2", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); check("release_1", 4'd1, 1'b0, 1'b0);
    step(); check("release_2", 4'd2, 1'b0, 1'b0);
    step(); check("release_3", 4'd3, 1'b0, 1'b0);

    // up across the top boundary
    do_reset();
    counter = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
`ifdef UP_DOWN_COUNTER_SATURATE_EN
      e  = (i >= 15) ? 4'd15 : 4'(i);
      eo = (i >= 16);
`else
      e  = 4'(i % 16);
      eo = (i == 16);
`endif
      check($sformatf("up_%0d", i), e, eo, 1'b0);
    end
    counter = 1'b0;
    step();
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    check("leave_max", 4'd14, 1'b0, 1'b0);
`else
    check("down_after_wrap", 4'd3, 1'b0, 1'b0);
`endif

    // down across zero
    do_reset();
    counter = 1'b0;
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    step(); check("down_sat_1", 4'd0, 1'b0, 1'b1);
    step(); check("down_sat_2", 4'd0, 1'b0, 1'b1);
    counter = 1'b1;
    step(); check("leave_min", 4'd1, 1'b0, 1'b0);
`else
    step(); check("down_wrap", 4'd15, 1'b0, 1'b1);
    step(); check("down_14", 4'd14, 1'b0, 1'b0);
    step(); check("down_13", 4'd13, 1'b0, 1'b0);
`endif

    // direction reversal
    do_reset();
    counter = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rev_at5", 4'd5, 1'b0, 1'b0);
    counter = 1'b0; step(); check("rev_4a", 4'd4, 1'b0, 1'b0);
    counter = 1'b1; step(); check("rev_5a", 4'd5, 1'b0, 1'b0);
    counter = 1'b0; step(); check("rev_4b", 4'd4, 1'b0, 1'b0);
    counter = 1'b1; step(); check("rev_5b", 4'd5, 1'b0, 1'b0);
    counter = 1'b0; step(); check("rev_4c", 4'd4, 1'b0, 1'b0);

    // reset in the middle of counting
    do_reset();
    counter = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("mid_at9", 4'd9, 1'b0, 1'b0);
    rst = 1'b1;
    step(); check("mid_reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); check("mid_resume1", 4'd1, 1'b0, 1'b0);
    step(); check("mid_resume2", 4'd2, 1'b0, 1'b0);

    // flag raised, then reset clears it
    do_reset();
    counter = 1'b0;
    step();
    rst = 1'b1;
    step(); check("flag_cleared_by_reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
- Synchronous binary up/down counter with a single clock domain.
- The 1-bit `counter` direction input selects increment or decrement every clock cycle.
- The registered `count` output wraps modulo 2^WIDTH by default.
- Used as a leaf timing/sequence block; provides single-cycle wrap flags for downstream event logic.

Parameters:
- WIDTH, 4, bit width of `count`; legal range 2..32.
- RESET_VAL, 0, value loaded into `count` on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  reset; synchronous, active-high.
- counter  input  1  direction select: 1 = count up, 0 = count down.
- count  output  WIDTH  current counter value, registered.
- ovf  output  1  registered pulse: up-count wrapped (or saturated) from max.
- unf  output  1  registered pulse: down-count wrapped (or saturated) from 0.

Behaviour:
- All state updates on the rising edge of clk; no combinational input-to-output paths.
- Reset (rst=1 at a rising edge):
  - count <= RESET_VAL; ovf <= 0; unf <= 0.
  - Reset has priority over counting.
  - Reset asserted mid-count takes effect at the next edge; no partial update.
- Normal operation (rst=0), evaluated every edge, one step per cycle:
  - counter=1: count <= count + 1.
  - counter=0: count <= count - 1.
- Wrap:
  - Up from 2^WIDTH-1 gives 0, with ovf=1 for that one cycle (registered alongside the new count).
  - Down from 0 gives 2^WIDTH-1, with unf=1 for that one cycle.
- ovf and unf are never both 1.
- Both flags are 0 on every cycle without a boundary crossing.
- Direction change: `counter` is sampled at each edge; reversing takes effect on the very next edge with no dead cycle.
- Latency: count reflects the sampled direction one cycle after the edge that sampled it; flags align with count.
- Arithmetic is unsigned WIDTH-bit, modulo 2^WIDTH; no X propagation from an undriven `counter`.
  - Treat X/Z on `counter` as implementation-undefined; the bench must drive 0/1.
- After reset release, the first step occurs at the first edge with rst=0.

Optional Feature:
- Macro: UP_DOWN_COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping.
  - Up at 2^WIDTH-1 holds 2^WIDTH-1 with ovf=1 every cycle it attempts to exceed.
  - Down at 0 holds 0 with unf=1 every cycle it attempts to go below.
  - Leaving the boundary clears the flag on the next edge.
- Undefined: wrap behaviour as above; no saturation logic is compiled.

Test Plan:
- Reset: hold rst=1 for 2 edges with counter=1 → count=0, ovf=0, unf=0; release rst, counter=1 → count 1, 2, 3 on successive edges.
- Up wrap (WIDTH=4): count up 16 edges from 0 → count reaches 15, then 0, with ovf=1 only on the cycle count=0; unf=0 throughout.
- Down wrap: from reset (0) drive counter=0 → count=15 with unf=1 for one cycle, then 14, 13 with unf=0.
- Direction reversal: count up to 5, set counter=0 → next edge count=4; toggle counter every cycle → count alternates 5/4.
- Reset mid-operation: at count=9 assert rst for 1 edge → count=0 and flags=0 at that edge; counting resumes from 0 on release.
- Saturation (UP_DOWN_COUNTER_SATURATE_EN defined): count up 20 edges → count holds 15, ovf=1 from the 16th edge onward; switch to down → count 14, ovf=0.
